adt7320_emu: RTL and testbench

- Synthesizable SPI responder emulating the ADT7320 temperature sensor's serial interface and register file.
- Lets the temperature readout master, and any future write-capable master, be exercised in loopback on the FPGA or in simulation without the physical chip.
- Sits on the far end of the cs/sclk/din/dout wires, in the 100 MHz clk domain.
- Oversamples the SPI lines, decodes the command byte, shifts register data out on dout and commits register writes.

---
 rtl/adt7320_emu.sv | 216 +++++++++++++++++++++
 tb/tb_adt7320_emu.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/adt7320_emu.sv
// ADT7320 SPI responder: emulates the sensor's serial protocol and register file so the
// temperature readout master can be exercised in loopback without the physical chip.
// SPI mode 3 (sclk idles high). All SPI lines are synchronized into the clk domain.

module adt7320_emu #(
   parameter logic [7:0]  CHIP_ID    = 8'hC3,
   parameter logic [15:0] TCRIT_INIT = 16'h4980,
   parameter logic [7:0]  THYST_INIT = 8'h05,
   parameter logic [15:0] THIGH_INIT = 16'h2000,
   parameter logic [15:0] TLOW_INIT  = 16'h0500
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cs,
   input  logic        sclk,
   input  logic        din,
   output logic        dout,
   input  logic [15:0] temp_value,
   output logic [7:0]  config_reg,
   output logic [15:0] tcrit,
   output logic [7:0]  thyst,
   output logic [15:0] thigh,
   output logic [15:0] tlow,
   output logic        wr_strobe,
   output logic [2:0]  wr_addr,
   output logic        cmd_err
);

   typedef enum logic [2:0] {StIdle, StCmd, StRd, StWr, StDone} state_t;

   // Bit counter values: 8 command bits, then up to 16 data bits.
   localparam logic [4:0] LastCmdBit  = 5'd7;
   localparam logic [4:0] Last8DatBit = 5'd15;
   localparam logic [4:0] Last16DatBit = 5'd23;
   localparam logic [4:0] FrameEnd    = 5'd24;

   logic cs_meta, cs_sync, cs_prev;
   logic sclk_meta, sclk_sync, sclk_prev;
   logic din_meta, din_sync;

   state_t      state_q;
   logic [4:0]  bit_cnt_q;
   logic [7:0]  cmd_q;
   logic [15:0] shift_q;
   logic [2:0]  addr_q;
   logic        is16_q;

   logic        cs_fall, sclk_rise, sclk_fall;
   logic [7:0]  cmd_next;
   logic [15:0] shift_next;
   logic        cmd_bad, cmd_rd, addr_is16, addr_writable, wr_last;
   logic [2:0]  cmd_addr;
   logic [15:0] read_word;

   // Two-flop synchronizers plus one history flop for edge detection.
   // cs is reset low so that a cs already low at reset release is not seen as a falling edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         cs_meta   <= 1'b0;
         cs_sync   <= 1'b0;
         cs_prev   <= 1'b0;
         sclk_meta <= 1'b1;
         sclk_sync <= 1'b1;
         sclk_prev <= 1'b1;
         din_meta  <= 1'b0;
         din_sync  <= 1'b0;
      end else begin
         cs_meta   <= cs;
         cs_sync   <= cs_meta;
         cs_prev   <= cs_sync;
         sclk_meta <= sclk;
         sclk_sync <= sclk_meta;
         sclk_prev <= sclk_sync;
         din_meta  <= din;
         din_sync  <= din_meta;
      end
   end

   // Edge strobes and command decode of the byte as it will look after the current shift.
   always_comb begin
      cs_fall    = cs_prev & ~cs_sync;
      sclk_rise  = sclk_sync & ~sclk_prev;
      sclk_fall  = ~sclk_sync & sclk_prev;
      cmd_next   = {cmd_q[6:0], din_sync};
      shift_next = {shift_q[14:0], din_sync};
      cmd_bad    = cmd_next[7] | (cmd_next[2:0] != 3'b000);
      cmd_rd     = cmd_next[6];
      cmd_addr   = cmd_next[5:3];
      addr_is16  = (cmd_addr == 3'd2) || (cmd_addr == 3'd4) || (cmd_addr == 3'd6) ||
                   (cmd_addr == 3'd7);
      addr_writable = (cmd_addr == 3'd1) || (cmd_addr == 3'd4) || (cmd_addr == 3'd5) ||
                      (cmd_addr == 3'd6) || (cmd_addr == 3'd7);
      wr_last    = is16_q ? (bit_cnt_q == Last16DatBit) : (bit_cnt_q == Last8DatBit);
   end

   // Read mux; 8-bit registers are left-justified so the MSB goes out first.
   always_comb begin
      read_word = 16'h0000;
      case (cmd_addr)
         3'd0:    read_word = 16'h0000;
         3'd1:    read_word = {config_reg, 8'h00};
         3'd2:    read_word = temp_value;
         3'd3:    read_word = {CHIP_ID, 8'h00};
         3'd4:    read_word = tcrit;
         3'd5:    read_word = {thyst, 8'h00};
         3'd6:    read_word = thigh;
         3'd7:    read_word = tlow;
         default: read_word = 16'h0000;
      endcase
   end

   // Protocol FSM with registered dout, register file and strobes.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         bit_cnt_q  <= 5'd0;
         cmd_q      <= 8'h00;
         shift_q    <= 16'h0000;
         addr_q     <= 3'd0;
         is16_q     <= 1'b0;
         dout       <= 1'b1;
         config_reg <= 8'h00;
         tcrit      <= TCRIT_INIT;
         thyst      <= THYST_INIT;
         thigh      <= THIGH_INIT;
         tlow       <= TLOW_INIT;
         wr_addr    <= 3'd0;
         wr_strobe  <= 1'b0;
         cmd_err    <= 1'b0;
      end else begin
         wr_strobe <= 1'b0;
         cmd_err   <= 1'b0;
         if (cs_sync) begin
            // Deselect aborts any frame; a partial write is simply dropped.
            state_q   <= StIdle;
            bit_cnt_q <= 5'd0;
            dout      <= 1'b1;
         end else begin
            case (state_q)
               StIdle: begin
                  dout      <= 1'b1;
                  bit_cnt_q <= 5'd0;
                  if (cs_fall) begin
                     state_q <= StCmd;
                  end
               end
               StCmd: begin
                  if (sclk_rise) begin
                     cmd_q     <= cmd_next;
                     bit_cnt_q <= bit_cnt_q + 5'd1;
                     if (bit_cnt_q == LastCmdBit) begin
                        addr_q <= cmd_addr;
                        is16_q <= addr_is16;
                        if (cmd_bad) begin
                           cmd_err <= 1'b1;
                           dout    <= 1'b0;
                           state_q <= StDone;
                        end else if (cmd_rd) begin
                           // temp_value is captured here so it is stable for the frame.
                           shift_q <= read_word;
                           state_q <= StRd;
                        end else if (addr_writable) begin
                           shift_q <= 16'h0000;
                           state_q <= StWr;
                        end else begin
                           cmd_err <= 1'b1;
                           dout    <= 1'b0;
                           state_q <= StDone;
                        end
                     end
                  end
               end
               StRd: begin
                  if (sclk_fall && (bit_cnt_q < FrameEnd)) begin
                     dout      <= shift_q[15];
                     shift_q   <= {shift_q[14:0], 1'b0};
                     bit_cnt_q <= bit_cnt_q + 5'd1;
                  end else if (sclk_rise && (bit_cnt_q == FrameEnd)) begin
                     // Leave only after the master sampled the last bit on this rising edge.
                     dout    <= 1'b0;
                     state_q <= StDone;
                  end
               end
               StWr: begin
                  if (sclk_rise) begin
                     shift_q   <= shift_next;
                     bit_cnt_q <= bit_cnt_q + 5'd1;
                     if (wr_last) begin
                        case (addr_q)
                           3'd1:    config_reg <= shift_next[7:0];
                           3'd4:    tcrit      <= shift_next;
                           3'd5:    thyst      <= shift_next[7:0];
                           3'd6:    thigh      <= shift_next;
                           3'd7:    tlow       <= shift_next;
                           default: ;
                        endcase
                        wr_addr   <= addr_q;
                        wr_strobe <= 1'b1;
                        dout      <= 1'b0;
                        state_q   <= StDone;
                     end
                  end
               end
               StDone: begin
                  dout <= 1'b0;
               end
               default: begin
                  state_q <= StIdle;
                  dout    <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_adt7320_emu.sv
// Bench for adt7320_emu: a bit-banged SPI mode-3 master drives directed frames; expected
// events (read results, write commits, command errors) are queued at issue time and a
// monitor on the falling clk edge pops and compares them as the DUT produces them.

module tb_adt7320_emu;

   localparam int HP = 10;  // clk cycles per sclk phase
   localparam logic [1:0] KRd = 2'd0, KWr = 2'd1, KErr = 2'd2;

   typedef struct {
      logic [1:0]  kind;
      logic [18:0] val;
   } ev_t;

   logic        clk = 1'b0;
   logic        reset, cs, sclk, din, dout;
   logic [15:0] temp_value, temp_next;
   logic [7:0]  config_reg, thyst;
   logic [15:0] tcrit, thigh, tlow;
   logic        wr_strobe, cmd_err;
   logic [2:0]  wr_addr;

   ev_t         exp_q[$];
   logic [15:0] got_q[$];
   int          checks = 0;
   int          errors = 0;

   adt7320_emu dut (
      .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .din(din), .dout(dout),
      .temp_value(temp_value), .config_reg(config_reg), .tcrit(tcrit), .thyst(thyst),
      .thigh(thigh), .tlow(tlow), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .cmd_err(cmd_err)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] reg_of(input logic [2:0] a);
      case (a)
         3'd1:    return {8'h00, config_reg};
         3'd4:    return tcrit;
         3'd5:    return {8'h00, thyst};
         3'd6:    return thigh;
         3'd7:    return tlow;
         default: return 16'h0000;
      endcase
   endfunction

   task automatic sb_check(input logic [1:0] kind, input logic [18:0] val, input string name);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: unexpected event kind=%0d val=%h, nothing expected", name, kind, val);
      end else begin
         e = exp_q.pop_front();
         if (e.kind !== kind || e.val !== val) begin
            errors++;
            $display("FAIL %s: got kind=%0d val=%h, expected kind=%0d val=%h",
                     name, kind, val, e.kind, e.val);
         end
      end
   endtask

   // Monitor: DUT events and completed master reads are compared against the queue.
   always @(negedge clk) begin
      if (wr_strobe) sb_check(KWr, {wr_addr, reg_of(wr_addr)}, "wr_commit");
      if (cmd_err) sb_check(KErr, 19'd0, "cmd_err");
      if (got_q.size() > 0) sb_check(KRd, {3'd0, got_q.pop_front()}, "rd_data");
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [1:0] kind, input logic [18:0] val);
      ev_t e;
      e.kind = kind;
      e.val  = val;
      exp_q.push_back(e);
   endtask

   // One SPI frame: 8 command bits then ndata data bits; optional reset pulse before data
   // bit rst_at. dout is sampled at each rising sclk edge of the data phase.
   task automatic spi_frame(input logic [7:0] cmd, input int ndata, input logic [15:0] wdata,
                            input int rst_at, output logic [15:0] rdata);
      logic [15:0] r;
      r  = 16'h0000;
      cs = 1'b0;
      clks(HP);
      for (int i = 0; i < 8; i++) begin
         sclk = 1'b0;
         din  = cmd[7-i];
         clks(HP);
         sclk = 1'b1;
         clks(HP);
      end
      temp_value = temp_next;
      for (int i = 0; i < ndata; i++) begin
         if (i == rst_at) begin
            reset = 1'b1;
            clks(1);
            reset = 1'b0;
            chk("dout_after_reset", {15'd0, dout}, 16'h0001);
         end
         sclk = 1'b0;
         din  = wdata[ndata-1-i];
         clks(HP);
         r    = {r[14:0], dout};
         sclk = 1'b1;
         clks(HP);
      end
      cs  = 1'b1;
      din = 1'b0;
      clks(HP);
      rdata = r;
   endtask

   task automatic rd(input logic [7:0] cmd, input logic [15:0] exp);
      logic [15:0] r;
      push(KRd, {3'd0, exp});
      spi_frame(cmd, 16, 16'h0000, -1, r);
      got_q.push_back(r);
   endtask

   task automatic wr(input logic [7:0] cmd, input int n, input logic [15:0] d);
      logic [15:0] r;
      push(KWr, {cmd[5:3], d});
      spi_frame(cmd, n, d, -1, r);
   endtask

   task automatic bad(input logic [7:0] cmd);
      logic [15:0] r;
      push(KErr, 19'd0);
      push(KRd, 19'd0);
      spi_frame(cmd, 16, 16'h0000, -1, r);
      got_q.push_back(r);
   endtask

   initial begin
      logic [15:0] r;
      reset = 1'b1; cs = 1'b1; sclk = 1'b1; din = 1'b0;
      temp_value = 16'h0000; temp_next = 16'h0000;
      clks(5);
      chk("rst_dout", {15'd0, dout}, 16'h0001);
      chk("rst_config", {8'h00, config_reg}, 16'h0000);
      chk("rst_tcrit", tcrit, 16'h4980);
      chk("rst_thyst", {8'h00, thyst}, 16'h0005);
      chk("rst_thigh", thigh, 16'h2000);
      chk("rst_tlow", tlow, 16'h0500);
      chk("rst_wr_addr", {13'd0, wr_addr}, 16'h0000);
      chk("rst_wr_strobe", {15'd0, wr_strobe}, 16'h0000);
      chk("rst_cmd_err", {15'd0, cmd_err}, 16'h0000);
      reset = 1'b0;
      clks(5);

      // Chip ID read
      rd(8'h58, 16'hC300);
      // Temperature captured at command decode
      temp_value = 16'h0C80;
      temp_next  = 16'hFFFF;
      rd(8'h50, 16'h0C80);
      // Config write then read back
      wr(8'h08, 8, 16'h0040);
      chk("config_after_wr", {8'h00, config_reg}, 16'h0040);
      chk("wr_addr_config", {13'd0, wr_addr}, 16'h0001);
      rd(8'h48, 16'h4000);
      // Aborted Thigh write: no commit expected
      spi_frame(8'h30, 10, 16'h02CD, -1, r);
      chk("thigh_after_abort", thigh, 16'h2000);
      wr(8'h30, 16, 16'h1234);
      chk("thigh_after_wr", thigh, 16'h1234);
      chk("wr_addr_thigh", {13'd0, wr_addr}, 16'h0006);
      // Malformed command and write to read-only temp register
      bad(8'h81);
      bad(8'h10);
      chk("thigh_after_err", thigh, 16'h1234);
      chk("config_after_err", {8'h00, config_reg}, 16'h0040);
      chk("tlow_unchanged", tlow, 16'h0500);
      // Tcrit write, then reset in the data phase of a Tcrit read:
      // bits 0..2 of 16'h1111 are 000, everything after the reset reads as 1.
      wr(8'h20, 16, 16'h1111);
      chk("tcrit_after_wr", tcrit, 16'h1111);
      push(KRd, {3'd0, 16'h1FFF});
      spi_frame(8'h60, 16, 16'h0000, 3, r);
      got_q.push_back(r);
      chk("tcrit_after_reset", tcrit, 16'h4980);
      chk("config_after_reset", {8'h00, config_reg}, 16'h0000);
      chk("wr_addr_after_reset", {13'd0, wr_addr}, 16'h0000);
      rd(8'h60, 16'h4980);

      clks(50);
      chk("exp_queue_left", exp_q.size(), 16'd0);
      chk("got_queue_left", got_q.size(), 16'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
